// File: rtl/scara_pkg.sv
// Shared types and constants for the SCARA joint-solver datapath.
package scara_pkg;

    typedef logic [63:0] double_t;

    // Jacobian-transpose step sequencer states, in execution order.
    typedef enum logic [3:0] {
        IDLE, M0, M1, A0, M2, M3, A1, S0, S1, DONE
    } jts_state_e;

    localparam double_t DBL_ZERO = 64'h0000_0000_0000_0000;
    localparam double_t DBL_ONE  = 64'h3FF0_0000_0000_0000;
    localparam double_t DBL_QNAN = 64'h7FF8_0000_0000_0000;

    // Successor of each arithmetic step; the last step hands off to DONE.
    function automatic jts_state_e jts_next_step(input jts_state_e s);
        case (s)
            M0:      return M1;
            M1:      return A0;
            A0:      return M2;
            M2:      return M3;
            M3:      return A1;
            A1:      return S0;
            S0:      return S1;
            S1:      return DONE;
            default: return IDLE;
        endcase
    endfunction

    // True for states that own a core operation.
    function automatic logic jts_is_step(input jts_state_e s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/double_adder.sv
// IEEE-754 double adder core: round-to-nearest-even, subnormals flushed to zero.
// Result and data_ready appear one cycle after in_ready; reset is active-high.
module DoubleAdder
    import scara_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] data_out,
    output logic        data_ready
);

    function automatic logic [63:0] dadd(input logic [63:0] p, input logic [63:0] q);
        logic [63:0]        x, y;
        logic [55:0]        mx, my, sh;
        logic [56:0]        sum;
        logic [53:0]        rnd;
        logic [10:0]        d;
        logic signed [12:0] e;
        if (p[62:52] == 11'h7FF && p[51:0] != 52'd0) return p;
        if (q[62:52] == 11'h7FF && q[51:0] != 52'd0) return q;
        if (p[62:52] == 11'h7FF && q[62:52] == 11'h7FF && p[63] != q[63]) return DBL_QNAN;
        if (p[62:52] == 11'h7FF) return p;
        if (q[62:52] == 11'h7FF) return q;
        if (p[62:52] == 11'd0 && q[62:52] == 11'd0) return {p[63] & q[63], 63'd0};
        if (p[62:52] == 11'd0) return q;
        if (q[62:52] == 11'd0) return p;
        if (p[62:0] >= q[62:0]) begin x = p; y = q; end
        else                    begin x = q; y = p; end
        mx = {1'b1, x[51:0], 3'b000};
        my = {1'b1, y[51:0], 3'b000};
        d  = x[62:52] - y[62:52];
        // Align the smaller operand, folding shifted-out bits into a sticky LSB.
        if (d > 11'd55) sh = 56'd1;
        else begin
            sh = my >> d;
            if ((sh << d) != my) sh[0] = 1'b1;
        end
        e = $signed({2'b00, x[62:52]});
        if (x[63] == y[63]) sum = {1'b0, mx} + {1'b0, sh};
        else                sum = {1'b0, mx} - {1'b0, sh};
        if (sum == 57'd0) return DBL_ZERO;
        if (sum[56]) begin
            sum = {1'b0, sum[56:2], sum[1] | sum[0]};
            e   = e + 13'sd1;
        end else begin
            for (int i = 0; i < 56; i++) begin
                if (!sum[55]) begin
                    sum = sum << 1;
                    e   = e - 13'sd1;
                end
            end
        end
        rnd = {1'b0, sum[55:3]};
        if (sum[2] && ((sum[1] | sum[0]) || sum[3])) rnd = rnd + 54'd1;
        if (rnd[53]) begin
            rnd = rnd >> 1;
            e   = e + 13'sd1;
        end
        if (e >= 13'sd2047) return {x[63], 11'h7FF, 52'd0};
        if (e <= 13'sd0)    return {x[63], 63'd0};
        return {x[63], e[10:0], rnd[51:0]};
    endfunction

    // Register the sum and flag it one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ready <= 1'b0;
            data_out   <= DBL_ZERO;
        end else begin
            data_ready <= in_ready;
            if (in_ready) data_out <= dadd(a, b);
        end
    end

endmodule

// File: rtl/double_multiply.sv
// IEEE-754 double multiplier core: round-to-nearest-even, subnormals flushed to zero.
// Result and data_ready appear one cycle after in_ready.
module DoubleMultiply
    import scara_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] data_out,
    output logic        data_ready
);

    function automatic logic [63:0] dmul(input logic [63:0] x, input logic [63:0] y);
        logic               sgn;
        logic [10:0]        ex, ey;
        logic [105:0]       prod;
        logic [53:0]        mant;
        logic               g, st;
        logic signed [12:0] e;
        sgn = x[63] ^ y[63];
        ex  = x[62:52];
        ey  = y[62:52];
        if (ex == 11'h7FF && x[51:0] != 52'd0) return x;
        if (ey == 11'h7FF && y[51:0] != 52'd0) return y;
        if (ex == 11'h7FF || ey == 11'h7FF) begin
            if (ex == 11'd0 || ey == 11'd0) return DBL_QNAN;
            return {sgn, 11'h7FF, 52'd0};
        end
        if (ex == 11'd0 || ey == 11'd0) return {sgn, 63'd0};
        prod = {53'd0, 1'b1, x[51:0]} * {53'd0, 1'b1, y[51:0]};
        e    = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 13'sd1023;
        if (prod[105]) begin
            mant = {1'b0, prod[105:53]};
            g    = prod[52];
            st   = |prod[51:0];
            e    = e + 13'sd1;
        end else begin
            mant = {1'b0, prod[104:52]};
            g    = prod[51];
            st   = |prod[50:0];
        end
        if (g && (st || mant[0])) mant = mant + 54'd1;
        if (mant[53]) begin
            mant = mant >> 1;
            e    = e + 13'sd1;
        end
        if (e >= 13'sd2047) return {sgn, 11'h7FF, 52'd0};
        if (e <= 13'sd0)    return {sgn, 63'd0};
        return {sgn, e[10:0], mant[51:0]};
    endfunction

    // Register the product and flag it one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ready <= 1'b0;
            data_out   <= DBL_ZERO;
        end else begin
            data_ready <= in_ready;
            if (in_ready) data_out <= dmul(a, b);
        end
    end

endmodule

// File: rtl/jts_opmux.sv
// Operand select for the shared multiplier and adder, indexed by step state.
module jts_opmux
    import scara_pkg::*;
(
    input  jts_state_e  state_i,
    input  logic [63:0] dx1_i,
    input  logic [63:0] dx2_i,
    input  logic [63:0] dy1_i,
    input  logic [63:0] dy2_i,
    input  logic [63:0] ex_i,
    input  logic [63:0] ey_i,
    input  logic [63:0] alpha_i,
    input  logic [63:0] p0_i,
    input  logic [63:0] p1_i,
    input  logic [63:0] p2_i,
    input  logic [63:0] p3_i,
    input  logic [63:0] s0_i,
    input  logic [63:0] s1_i,
    output logic [63:0] mul_a_o,
    output logic [63:0] mul_b_o,
    output logic [63:0] add_a_o,
    output logic [63:0] add_b_o,
    output logic        use_add_o
);

    // Route the operands of the current step; idle operands are benign constants.
    always_comb begin
        mul_a_o   = DBL_ZERO;
        mul_b_o   = DBL_ONE;
        add_a_o   = DBL_ZERO;
        add_b_o   = DBL_ZERO;
        use_add_o = 1'b0;
        case (state_i)
            M0:      begin mul_a_o = dx1_i;   mul_b_o = ex_i; end
            M1:      begin mul_a_o = dy1_i;   mul_b_o = ey_i; end
            A0:      begin add_a_o = p0_i;    add_b_o = p1_i; use_add_o = 1'b1; end
            M2:      begin mul_a_o = dx2_i;   mul_b_o = ex_i; end
            M3:      begin mul_a_o = dy2_i;   mul_b_o = ey_i; end
            A1:      begin add_a_o = p2_i;    add_b_o = p3_i; use_add_o = 1'b1; end
            S0:      begin mul_a_o = alpha_i; mul_b_o = s0_i; end
            S1:      begin mul_a_o = alpha_i; mul_b_o = s1_i; end
            default: ;
        endcase
    end

endmodule

// File: rtl/jacobian_transpose_step.sv
// Jacobian-transpose joint increment: dth = alpha * J^T * e, sequenced over one
// shared multiplier and one shared adder, with a per-step watchdog.
module jacobian_transpose_step
    import scara_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jac_valid,
    input  logic [63:0] dx_dth1,
    input  logic [63:0] dx_dth2,
    input  logic [63:0] dy_dth1,
    input  logic [63:0] dy_dth2,
    input  logic [63:0] ex,
    input  logic [63:0] ey,
    input  logic [63:0] alpha,
    output logic        busy,
    output logic [63:0] dth1,
    output logic [63:0] dth2,
    output logic        out_valid,
    output logic        err
);

    jts_state_e    state_q, state_d;
    logic          entry_q, entry_d;
    logic [TW-1:0] wd_q, wd_d;
    logic          busy_q, out_valid_q, err_q;
    double_t       dx1_q, dx2_q, dy1_q, dy2_q, ex_q, ey_q, alpha_q;
    double_t       p0_q, p1_q, p2_q, p3_q, s0_q, s1_q, n1_q, n2_q;
    double_t       dth1_q, dth2_q;
    double_t       mul_a, mul_b, add_a, add_b, mul_res, add_res, core_res;
    logic          use_add, mul_go, add_go, mul_rdy_core, mul_rdy, add_rdy, core_rdy;
    logic          capture, step_done, abort;

    jts_opmux u_opmux (
        .state_i  (state_q),
        .dx1_i    (dx1_q),
        .dx2_i    (dx2_q),
        .dy1_i    (dy1_q),
        .dy2_i    (dy2_q),
        .ex_i     (ex_q),
        .ey_i     (ey_q),
        .alpha_i  (alpha_q),
        .p0_i     (p0_q),
        .p1_i     (p1_q),
        .p2_i     (p2_q),
        .p3_i     (p3_q),
        .s0_i     (s0_q),
        .s1_i     (s1_q),
        .mul_a_o  (mul_a),
        .mul_b_o  (mul_b),
        .add_a_o  (add_a),
        .add_b_o  (add_b),
        .use_add_o(use_add)
    );

    // Request pulses only on the first cycle of a step.
    assign mul_go = entry_q & ~use_add;
    assign add_go = entry_q & use_add;

    DoubleMultiply u_mul (
        .clk       (clk),
        .reset     (~reset),
        .in_ready  (mul_go),
        .a         (mul_a),
        .b         (mul_b),
        .data_out  (mul_res),
        .data_ready(mul_rdy_core)
    );

    DoubleAdder u_add (
        .clk       (clk),
        .reset     (~reset),
        .in_ready  (add_go),
        .a         (add_a),
        .b         (add_b),
        .data_out  (add_res),
        .data_ready(add_rdy)
    );

    assign mul_rdy   = mul_rdy_core;
    assign core_rdy  = use_add ? add_rdy : mul_rdy;
    assign core_res  = use_add ? add_res : mul_res;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign dth1      = dth1_q;
    assign dth2      = dth2_q;

    // Next-state: capture in IDLE, advance on core ready, abort on watchdog expiry.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        step_done = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (jac_valid) begin
                    capture = 1'b1;
                    state_d = M0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (core_rdy) begin
                    step_done = 1'b1;
                    state_d   = jts_next_step(state_q);
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        entry_d = (state_d != state_q) && jts_is_step(state_d);
        wd_d    = (entry_d || !jts_is_step(state_q)) ? '0 : wd_q + TW'(1);
    end

    // Control state: FSM, step-entry flag, watchdog and status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            entry_q     <= 1'b0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            wd_q        <= wd_d;
            out_valid_q <= (state_q == DONE);
            err_q       <= abort;
            if (capture)                          busy_q <= 1'b1;
            else if (state_q == DONE || abort)    busy_q <= 1'b0;
        end
    end

    // Datapath: input capture, per-step result latch and output update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dx1_q  <= DBL_ZERO; dx2_q <= DBL_ZERO; dy1_q <= DBL_ZERO; dy2_q <= DBL_ZERO;
            ex_q   <= DBL_ZERO; ey_q  <= DBL_ZERO; alpha_q <= DBL_ZERO;
            p0_q   <= DBL_ZERO; p1_q  <= DBL_ZERO; p2_q <= DBL_ZERO; p3_q <= DBL_ZERO;
            s0_q   <= DBL_ZERO; s1_q  <= DBL_ZERO; n1_q <= DBL_ZERO; n2_q <= DBL_ZERO;
            dth1_q <= DBL_ZERO; dth2_q <= DBL_ZERO;
        end else begin
            if (capture) begin
                dx1_q <= dx_dth1; dx2_q <= dx_dth2; dy1_q <= dy_dth1; dy2_q <= dy_dth2;
                ex_q  <= ex;      ey_q  <= ey;      alpha_q <= alpha;
            end
            if (step_done) begin
                case (state_q)
                    M0:      p0_q <= core_res;
                    M1:      p1_q <= core_res;
                    A0:      s0_q <= core_res;
                    M2:      p2_q <= core_res;
                    M3:      p3_q <= core_res;
                    A1:      s1_q <= core_res;
                    S0:      n1_q <= core_res;
                    S1:      n2_q <= core_res;
                    default: ;
                endcase
            end
            if (state_q == DONE) begin
                dth1_q <= n1_q;
                dth2_q <= n2_q;
            end
        end
    end

endmodule

// File: doc/jacobian_transpose_step.md
Name: jacobian_transpose_step

Overview:
- Downstream consumer of the Jacobian stage. Captures the four 64-bit double Jacobian terms plus a Cartesian position error (ex, ey) and a gain alpha.
- Computes joint increments using the Jacobian-transpose method:
  - dth1 = alpha*(dx_dth1*ex + dy_dth1*ey)
  - dth2 = alpha*(dx_dth2*ex + dy_dth2*ey)
- Time-multiplexes one DoubleMultiply and one DoubleAdder under an FSM. Results feed the joint setpoint integrator.

Parameters:
- TIMEOUT, 64, max cycles to wait for any single core data_ready before aborting with err.
- TW, 7, width of the watchdog counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- jac_valid  in  1  Jacobian terms valid; driven from Jacobian data_ready
- dx_dth1, dx_dth2, dy_dth1, dy_dth2  in  64 each  IEEE-754 double Jacobian terms
- ex, ey  in  64 each  double Cartesian error (target minus current)
- alpha  in  64  double step gain
- busy  out  1  high from capture until done/err
- dth1, dth2  out  64 each  double joint increments
- out_valid  out  1  one-cycle pulse when dth1/dth2 are updated
- err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Single clock; reset is synchronous, active-low.
- Reset (reset==0 at a clk edge), regardless of state:
  - FSM goes to IDLE.
  - busy, out_valid, err = 0; dth1, dth2 = 64'h0; all capture registers = 0; watchdog = 0.
- IDLE:
  - If jac_valid==1, register all seven input doubles, assert busy next cycle, and go to M0.
  - Inputs are not sampled again until return to IDLE. jac_valid while busy is ignored (no queueing).
- Operation sequence, one shared core per step:
  - M0: p0 = dx_dth1*ex
  - M1: p1 = dy_dth1*ey
  - A0: s0 = p0+p1
  - M2: p2 = dx_dth2*ex
  - M3: p3 = dy_dth2*ey
  - A1: s1 = p2+p3
  - S0: dth1_n = alpha*s0
  - S1: dth2_n = alpha*s1
  - DONE
- Step handshake:
  - Each state drives the core operand muxes and pulses in_ready for exactly 1 cycle on state entry.
  - It then waits for the core's data_ready, latches the result, and advances on the following cycle.
  - Operand muxes stay stable for the whole wait.
- DONE:
  - dth1 <= dth1_n, dth2 <= dth2_n; out_valid=1 for one cycle; busy=0 on the same cycle; return to IDLE.
  - jac_valid sampled in IDLE on the very next cycle is accepted (back-to-back, no dead cycle beyond DONE).
- Watchdog:
  - Counter clears on each step entry and increments while waiting.
  - If it reaches TIMEOUT: err pulses 1 cycle, busy=0, go to IDLE. dth1/dth2 keep their previous values and out_valid stays 0.
- Outputs dth1/dth2 hold their value between out_valid pulses.
- Arithmetic:
  - Pure IEEE double via the cores; no rounding or saturation in this block. NaN/Inf propagate unchanged.
  - Sign handling is the cores' job; no bit manipulation here.
- The DoubleAdder reset is driven as ~reset, because the core's reset is active-high.
- Latency, jac_valid to out_valid: 8 core operations + 8 step-advance cycles + 1 capture + 1 DONE.

Decomposition:
- Shared package scara_pkg holds:
  - double_t (logic [63:0]) typedef.
  - The FSM state enum (IDLE, M0, M1, A0, M2, M3, A1, S0, S1, DONE).
  - Constants DBL_ZERO, DBL_ONE.
- Natural sub-module: jts_opmux, a combinational operand-select for the shared multiplier/adder indexed by state. The FSM, capture registers and watchdog stay in the top.
- Cores reused unchanged: DoubleMultiply, DoubleAdder.

Test Plan:
- Basic solve:
  - Stimulus: dx_dth1=0xBFF0000000000000 (-1), dx_dth2=0xBFF0… (-1), dy_dth1=0x3FF0… (1), dy_dth2=0; ex=0x3FE0… (0.5), ey=0x3FD0… (0.25), alpha=0x3FF0… (1), jac_valid pulse.
  - Required: one out_valid with dth1=0xBFD0000000000000 (-0.25), dth2=0xBFE0000000000000 (-0.5); busy low that cycle.
- Gain scaling:
  - Stimulus: same inputs with alpha=0x3FE0… (0.5).
  - Required: dth1=0xBFC0… (-0.125), dth2=0xBFD0… (-0.25).
- Busy rejection:
  - Stimulus: second jac_valid with different ex asserted mid-operation.
  - Required: results match the first capture only; exactly one out_valid.
- Reset mid-operation:
  - Stimulus: reset=0 for 1 cycle during A1.
  - Required: next cycle busy=0, dth1=dth2=0, out_valid never pulses; a new jac_valid then produces a correct result.
- Watchdog:
  - Stimulus: force the multiplier data_ready low during M2.
  - Required: err pulses exactly TIMEOUT cycles after M2 entry, busy drops, dth1/dth2 retain prior values.
- Back-to-back:
  - Stimulus: jac_valid held high continuously.
  - Required: consecutive out_valid pulses spaced exactly one full latency apart, each with correct results.
